// File: rtl/barrel_pkg.sv
// Shared definitions for the barrel shifter and its request sequencer:
// default datapath sizes and the sequencer state encoding.
package barrel_pkg;

   localparam int DATA_SIZE_DEF = 8;
   localparam int SEL_W_DEF     = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   // next count: step only while below the ceiling
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/barrel_seq.sv
// Sequencer in front of barrel2: takes one request, pulses the shifter load,
// waits out its latency, then holds the result on a valid/ready response port.
module barrel_seq
   import barrel_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int SEL_W     = SEL_W_DEF,
   parameter int BRL_LAT   = 1,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [DATA_SIZE-1:0] req_data,
   input  logic [SEL_W-1:0]     req_sel,
   output logic                 brl_load,
   output logic [SEL_W-1:0]     brl_sel,
   output logic [DATA_SIZE-1:0] brl_data_in,
   input  logic [DATA_SIZE-1:0] brl_data_out,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATA_SIZE-1:0] rsp_data,
   output logic [SEL_W-1:0]     rsp_sel,
   output logic                 busy,
   output logic [CNT_W-1:0]     op_count
);

   generate
      if ((BRL_LAT < 1) || (BRL_LAT > 15)) begin : g_bad_lat
         $error("barrel_seq: BRL_LAT must lie in 1..15");
      end
      if (SEL_W != $clog2(DATA_SIZE)) begin : g_bad_sel
         $error("barrel_seq: SEL_W must equal clog2(DATA_SIZE)");
      end
   endgenerate

   localparam logic [3:0] WAIT_INIT = 4'(BRL_LAT - 1);

   seq_state_e           state_d,       state_q;
   logic                 brl_load_d,    brl_load_q;
   logic [SEL_W-1:0]     brl_sel_d,     brl_sel_q;
   logic [DATA_SIZE-1:0] brl_data_in_d, brl_data_in_q;
   logic [3:0]           wait_cnt_d,    wait_cnt_q;
   logic                 rsp_valid_d,   rsp_valid_q;
   logic [DATA_SIZE-1:0] rsp_data_d,    rsp_data_q;
   logic [SEL_W-1:0]     rsp_sel_d,     rsp_sel_q;
   logic                 busy_d,        busy_q;
   logic                 cnt_inc;

   // next-state and registered-output computation
   always_comb begin
      state_d       = state_q;
      brl_load_d    = 1'b0;
      brl_sel_d     = brl_sel_q;
      brl_data_in_d = brl_data_in_q;
      wait_cnt_d    = wait_cnt_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_sel_d     = rsp_sel_q;
      cnt_inc       = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               brl_data_in_d = req_data;
               brl_sel_d     = req_sel;
               brl_load_d    = 1'b1;
               state_d       = LOAD;
            end else begin
               state_d       = IDLE;
            end
         end
         LOAD: begin
            wait_cnt_d = WAIT_INIT;
            state_d    = WAIT;
         end
         WAIT: begin
            if (wait_cnt_q == 4'd0) begin
               rsp_data_d  = brl_data_out;
               rsp_sel_d   = brl_sel_q;
               rsp_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               wait_cnt_d  = wait_cnt_q - 4'd1;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cnt_inc     = 1'b1;
               state_d     = IDLE;
            end else begin
               state_d     = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         brl_load_q    <= 1'b0;
         brl_sel_q     <= '0;
         brl_data_in_q <= '0;
         wait_cnt_q    <= 4'd0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_sel_q     <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         brl_load_q    <= brl_load_d;
         brl_sel_q     <= brl_sel_d;
         brl_data_in_q <= brl_data_in_d;
         wait_cnt_q    <= wait_cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_sel_q     <= rsp_sel_d;
         busy_q        <= busy_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_op_count (
      .clk   (clk),
      .reset (reset),
      .inc   (cnt_inc),
      .count (op_count)
   );

   assign req_ready   = (state_q == IDLE);
   assign brl_load    = brl_load_q;
   assign brl_sel     = brl_sel_q;
   assign brl_data_in = brl_data_in_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_sel     = rsp_sel_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_barrel_seq.sv
// Bench for barrel_seq: two instances (latency 1 / 16-bit count, latency 4 / 2-bit count),
// each fed by a rotate-left shifter stub and checked every cycle against a transaction model.
module tb_barrel_seq;

   localparam int DW    = 8;
   localparam int SW    = 3;
   localparam int LAT_A = 1;
   localparam int LAT_B = 4;

   int lat_of  [2] = '{LAT_A, LAT_B};
   int cmax_of [2] = '{65535, 3};

   logic clk   = 1'b0;
   logic reset = 1'b1;

   logic [1:0]           req_valid = 2'b00;
   logic [1:0]           rsp_ready = 2'b11;
   logic [1:0]           req_ready, brl_load, rsp_valid, busy;
   logic [1:0][DW-1:0]   req_data = '0;
   logic [1:0][SW-1:0]   req_sel  = '0;
   logic [1:0][DW-1:0]   brl_data_in, brl_data_out, rsp_data;
   logic [1:0][SW-1:0]   brl_sel, rsp_sel;
   logic [15:0]          op_count_a;
   logic [1:0]           op_count_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rotl(input logic [DW-1:0] x, input logic [SW-1:0] s);
      logic [2*DW-1:0] t;
      t = {x, x} << s;
      return t[2*DW-1:DW];
   endfunction

   function automatic logic [15:0] cnt_of(input int d);
      return (d == 0) ? op_count_a : 16'(op_count_b);
   endfunction

   task automatic chk(input string nm, input int d, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s dut%0d: got %h expected %h", nm, d, got, exp);
      end
   endtask

   barrel_seq #(.DATA_SIZE(DW), .SEL_W(SW), .BRL_LAT(LAT_A), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_data(req_data[0]), .req_sel(req_sel[0]),
      .brl_load(brl_load[0]), .brl_sel(brl_sel[0]),
      .brl_data_in(brl_data_in[0]), .brl_data_out(brl_data_out[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_data(rsp_data[0]), .rsp_sel(rsp_sel[0]),
      .busy(busy[0]), .op_count(op_count_a)
   );

   barrel_seq #(.DATA_SIZE(DW), .SEL_W(SW), .BRL_LAT(LAT_B), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_data(req_data[1]), .req_sel(req_sel[1]),
      .brl_load(brl_load[1]), .brl_sel(brl_sel[1]),
      .brl_data_in(brl_data_in[1]), .brl_data_out(brl_data_out[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_data(rsp_data[1]), .rsp_sel(rsp_sel[1]),
      .busy(busy[1]), .op_count(op_count_b)
   );

   // shifter stub: rotate on load, result emerges after a LAT-deep delay line
   logic [1:0][3:0][DW-1:0] pipe;
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         pipe[d][0] <= brl_load[d] ? rotl(brl_data_in[d], brl_sel[d]) : pipe[d][0];
         for (int i = 1; i < 4; i++) pipe[d][i] <= pipe[d][i-1];
      end
   end
   assign brl_data_out[0] = pipe[0][LAT_A-1];
   assign brl_data_out[1] = pipe[1][LAT_B-1];

   // transaction model: age counts edges since the request was taken (-1 = nothing in flight)
   int            m_age    [2];
   int            m_cnt    [2];
   logic          m_rvalid [2];
   logic [DW-1:0] m_bdata  [2];
   logic [DW-1:0] m_rdata  [2];
   logic [SW-1:0] m_bsel   [2];
   logic [SW-1:0] m_rsel   [2];
   logic          model_ok = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) model_ok <= 1'b1;
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            m_age[d] <= -1; m_cnt[d] <= 0; m_rvalid[d] <= 1'b0;
            m_bdata[d] <= '0; m_bsel[d] <= '0; m_rdata[d] <= '0; m_rsel[d] <= '0;
         end else if (m_age[d] < 0) begin
            if (req_valid[d]) begin
               m_age[d] <= 0; m_bdata[d] <= req_data[d]; m_bsel[d] <= req_sel[d];
            end
         end else if (m_rvalid[d]) begin
            if (rsp_ready[d]) begin
               m_rvalid[d] <= 1'b0; m_age[d] <= -1;
               if (m_cnt[d] < cmax_of[d]) m_cnt[d] <= m_cnt[d] + 1;
            end
         end else begin
            m_age[d] <= m_age[d] + 1;
            if (m_age[d] + 1 == 1 + lat_of[d]) begin
               m_rvalid[d] <= 1'b1;
               m_rdata[d]  <= rotl(m_bdata[d], m_bsel[d]);
               m_rsel[d]   <= m_bsel[d];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         for (int d = 0; d < 2; d++) begin
            chk("req_ready",   d, 16'(req_ready[d]),   16'(m_age[d] < 0));
            chk("busy",        d, 16'(busy[d]),        16'(m_age[d] >= 0));
            chk("brl_load",    d, 16'(brl_load[d]),    16'(m_age[d] == 0));
            chk("brl_sel",     d, 16'(brl_sel[d]),     16'(m_bsel[d]));
            chk("brl_data_in", d, 16'(brl_data_in[d]), 16'(m_bdata[d]));
            chk("rsp_valid",   d, 16'(rsp_valid[d]),   16'(m_rvalid[d]));
            chk("rsp_data",    d, 16'(rsp_data[d]),    16'(m_rdata[d]));
            chk("rsp_sel",     d, 16'(rsp_sel[d]),     16'(m_rsel[d]));
            chk("op_count",    d, cnt_of(d),           16'(m_cnt[d]));
         end
      end
   end

   task automatic send(input int d, input logic [DW-1:0] data, input logic [SW-1:0] sel,
                       output int acc);
      req_valid[d] = 1'b1;
      req_data[d]  = data;
      req_sel[d]   = sel;
      acc = -1;
      for (int i = 0; i < 64 && acc < 0; i++) begin
         if (req_ready[d]) begin
            @(negedge clk);
            acc = cyc;
         end else begin
            @(negedge clk);
         end
      end
      req_valid[d] = 1'b0;
      if (acc < 0) begin
         total++; bad++;
         $display("FAIL accept_timeout dut%0d: got no accept expected accept", d);
      end else begin
         chk("load_pulse", d, 16'(brl_load[d]), 16'd1);
      end
   endtask

   task automatic run_op(input int d, input logic [DW-1:0] data, input logic [SW-1:0] sel,
                         output logic [DW-1:0] rd, output int lat);
      int   acc;
      logic seen;
      send(d, data, sel, acc);
      rd   = '0;
      lat  = -1;
      seen = 1'b0;
      if (acc >= 0) begin
         @(negedge clk);
         chk("load_drop", d, 16'(brl_load[d]), 16'd0);
         for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
               seen = 1'b1;
               rd   = rsp_data[d];
               lat  = cyc - acc + 1;
            end
         end
         if (!seen) begin
            total++; bad++;
            $display("FAIL rsp_timeout dut%0d: got no rsp_valid expected rsp_valid", d);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   logic [DW-1:0] rd;
   int            lat;
   int            acc5;
   logic [DW-1:0] t6_dat [5] = '{8'h01, 8'hF0, 8'h3C, 8'h80, 8'hAA};
   logic [SW-1:0] t6_sel [5] = '{3'd2, 3'd4, 3'd1, 3'd1, 3'd3};
   logic [DW-1:0] t6_exp [5] = '{8'h04, 8'h0F, 8'h78, 8'h01, 8'h55};
   logic [1:0]    t6_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // reset state
      for (int d = 0; d < 2; d++) begin
         chk("t1_req_ready", d, 16'(req_ready[d]), 16'd1);
         chk("t1_rsp_valid", d, 16'(rsp_valid[d]), 16'd0);
         chk("t1_brl_load",  d, 16'(brl_load[d]),  16'd0);
         chk("t1_op_count",  d, cnt_of(d),         16'd0);
      end

      // single operation, latency 1
      run_op(0, 8'b0000_0011, 3'd3, rd, lat);
      chk("t2_data", 0, 16'(rd), 16'(8'b0001_1000));
      chk("t2_lat",  0, 16'(lat), 16'd3);
      @(negedge clk);
      chk("t2_count", 0, op_count_a, 16'd1);

      // response held while a second request waits
      rsp_ready[0] = 1'b0;
      run_op(0, 8'h81, 3'd1, rd, lat);
      req_valid[0] = 1'b1; req_data[0] = 8'h3C; req_sel[0] = 3'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_req_ready", 0, 16'(req_ready[0]), 16'd0);
         chk("t3_rsp_data",  0, 16'(rsp_data[0]),  16'h0003);
         chk("t3_rsp_sel",   0, 16'(rsp_sel[0]),   16'd1);
      end
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      chk("t3_ready_after", 0, 16'(req_ready[0]), 16'd1);
      chk("t3_count",       0, op_count_a,         16'd2);
      run_op(0, 8'h3C, 3'd2, rd, lat);
      chk("t3_second", 0, 16'(rd), 16'h00F0);
      @(negedge clk);

      // select extremes
      run_op(0, 8'hA5, 3'd0, rd, lat);
      chk("t4_sel0", 0, 16'(rd), 16'h00A5);
      @(negedge clk);
      run_op(0, 8'h01, 3'd7, rd, lat);
      chk("t4_sel7", 0, 16'(rd), 16'h0080);
      @(negedge clk);
      chk("t4_count", 0, op_count_a, 16'd5);

      // reset while waiting on the shifter
      send(1, 8'h55, 3'd1, acc5);
      @(negedge clk);
      chk("t5_busy_before", 1, 16'(busy[1]), 16'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t5_busy",      1, 16'(busy[1]),      16'd0);
      chk("t5_req_ready", 1, 16'(req_ready[1]), 16'd1);
      chk("t5_rsp_valid", 1, 16'(rsp_valid[1]), 16'd0);
      chk("t5_op_count",  1, cnt_of(1),         16'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t5_no_stale", 1, 16'(rsp_valid[1]), 16'd0);
      end

      // saturating 2-bit count, latency 4
      for (int i = 0; i < 5; i++) begin
         run_op(1, t6_dat[i], t6_sel[i], rd, lat);
         chk("t6_data", 1, 16'(rd), 16'(t6_exp[i]));
         if (i == 0) chk("t6_lat", 1, 16'(lat), 16'd6);
         @(negedge clk);
         chk("t6_count", 1, cnt_of(1), 16'(t6_cnt[i]));
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
